// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and majority-vote helper
package uart_pkg;
    localparam int PAR_NONE  = 0;
    localparam int PAR_ODD   = 1;
    localparam int PAR_EVEN  = 2;
    localparam int OS_FACTOR = 16;
    localparam logic [3:0] SMP_A    = 4'd7;
    localparam logic [3:0] SMP_B    = 4'd8;
    localparam logic [3:0] SMP_EVAL = 4'd9;
    localparam logic [3:0] SMP_LAST = 4'd15;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} rx_state_t;
    function automatic logic majority(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: free-running divider producing a one-clk enable at BAUD_RATE*OS_FACTOR
module uart_os_tick #(
    parameter int CLK_RATE  = 100_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int OS_FACTOR = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLK_RATE / (BAUD_RATE * OS_FACTOR);
    localparam int W   = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with valid/ready byte output and error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 100_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 overrun,
    output logic                 busy
);
    rx_state_t state, state_n;
    logic tick, rxs, maj, eval, last, done;
    logic [1:0] sync, smp;
    logic [3:0] s;
    logic [2:0] idx;
    logic [DATA_BITS-1:0] shreg;
    logic par_err, frm_err;

    uart_os_tick #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .OS_FACTOR(OS_FACTOR)) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign rxs  = sync[1];
    assign maj  = majority({rxs, smp});
    assign eval = tick && s == SMP_EVAL;
    assign last = tick && s == SMP_LAST;
    assign done = eval && state == S_STOP && idx == 3'(STOP_BITS - 1);
    assign busy = state != S_IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_n;

    // The last stop bit completes at mid-bit so the next start edge is never missed
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = tick && !rxs ? S_START : state;
            S_START:  state_n = eval && maj ? S_IDLE : last ? S_DATA : state;
            S_DATA:   state_n = last && idx == 3'(DATA_BITS - 1) ? (PARITY != PAR_NONE ? S_PARITY : S_STOP) : state;
            S_PARITY: state_n = last ? S_STOP : state;
            S_STOP:   state_n = done ? (frm_err || !maj ? S_BREAK : S_IDLE) : state;
            S_BREAK:  state_n = tick && rxs ? S_IDLE : state;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync         <= 2'b11;
            smp          <= '0;
            s            <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_frame_err  <= 1'b0;
            m_parity_err <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            if (tick) begin
                s <= (state == S_IDLE || state == S_BREAK) ? '0 : s + 4'd1;
                if (s == SMP_A) smp[0] <= rxs;
                if (s == SMP_B) smp[1] <= rxs;
            end
            if (last) idx <= ((state == S_DATA && idx != 3'(DATA_BITS - 1)) || state == S_STOP) ? idx + 3'd1 : '0;
            if (eval && state == S_DATA) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (eval && state == S_PARITY) par_err <= maj != ((^shreg) ^ (PARITY == PAR_ODD));
            if (eval && state == S_STOP && !maj) frm_err <= 1'b1;
            if (state == S_IDLE) begin
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end
            overrun <= done && m_valid && !m_ready;
            if (done && (!m_valid || m_ready)) begin
                m_data       <= shreg;
                m_frame_err  <= frm_err || !maj;
                m_parity_err <= par_err;
                m_valid      <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (8N1 instance and 8E1 instance)
module tb_uart_rx;
    localparam int BIT = 160;
    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_p = 1'b1, m_ready = 1'b1, m_ready_p = 1'b1;
    logic [7:0] m_data, m_data_p;
    logic m_valid, m_frame_err, m_parity_err, overrun, busy;
    logic m_valid_p, m_frame_err_p, m_parity_err_p, overrun_p, busy_p;
    int checks = 0, errors = 0;
    int n_acc = 0, n_vhigh = 0, n_ovr = 0, n_acc_p = 0;
    logic [7:0] acc_data = '0, acc_data_p = '0;
    logic acc_fe = 1'b0, acc_pe = 1'b0, acc_pe_p = 1'b0, acc_fe_p = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLK_RATE(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_frame_err(m_frame_err), .m_parity_err(m_parity_err), .overrun(overrun), .busy(busy)
    );

    uart_rx #(.CLK_RATE(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .m_data(m_data_p), .m_valid(m_valid_p), .m_ready(m_ready_p),
        .m_frame_err(m_frame_err_p), .m_parity_err(m_parity_err_p), .overrun(overrun_p), .busy(busy_p)
    );

    always @(negedge clk) begin
        if (m_valid) n_vhigh <= n_vhigh + 1;
        if (overrun) n_ovr <= n_ovr + 1;
        if (m_valid && m_ready) begin
            n_acc    <= n_acc + 1;
            acc_data <= m_data;
            acc_fe   <= m_frame_err;
            acc_pe   <= m_parity_err;
        end
        if (m_valid_p && m_ready_p) begin
            n_acc_p    <= n_acc_p + 1;
            acc_data_p <= m_data_p;
            acc_pe_p   <= m_parity_err_p;
            acc_fe_p   <= m_frame_err_p;
        end
    end

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx_p = v;
        else rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic pbit, input logic stop_v);
        drive(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
        if (has_par) drive(sel, pbit, BIT);
        drive(sel, stop_v, BIT);
        drive(sel, 1'b1, 0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
        checks++; if ({m_frame_err, m_parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {m_frame_err, m_parity_err, overrun}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (m_valid_p !== 1'b0 || busy_p !== 1'b0) begin errors++; $display("FAIL reset_par_inst: got valid=%b busy=%b want 0 0", m_valid_p, busy_p); end
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_basic;
        int a0 = n_acc, v0 = n_vhigh;
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", n_acc - a0); end
        checks++; if (n_vhigh - v0 !== 1) begin errors++; $display("FAIL basic_valid_len: got %0d want 1", n_vhigh - v0); end
        checks++; if (acc_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", acc_data); end
        checks++; if ({acc_fe, acc_pe} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {acc_fe, acc_pe}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_parity;
        int a0 = n_acc_p;
        send(1, 8'h3C, 1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (acc_data_p !== 8'h3C) begin errors++; $display("FAIL par_ok_data: got %h want 3c", acc_data_p); end
        checks++; if (acc_pe_p !== 1'b0 || acc_fe_p !== 1'b0) begin errors++; $display("FAIL par_ok_flags: got pe=%b fe=%b want 0 0", acc_pe_p, acc_fe_p); end
        send(1, 8'h3C, 1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (acc_data_p !== 8'h3C) begin errors++; $display("FAIL par_bad_data: got %h want 3c", acc_data_p); end
        checks++; if (acc_pe_p !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", acc_pe_p); end
        checks++; if (n_acc_p - a0 !== 2) begin errors++; $display("FAIL par_count: got %0d want 2", n_acc_p - a0); end
    endtask

    task automatic test_break;
        int a0 = n_acc;
        send(0, 8'h55, 0, 1'b0, 1'b0);
        drive(0, 1'b0, 30 * BIT);
        checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL break_count: got %0d want 1", n_acc - a0); end
        checks++; if (acc_data !== 8'h55 || acc_fe !== 1'b1) begin errors++; $display("FAIL break_frame: got data=%h fe=%b want 55 1", acc_data, acc_fe); end
        drive(0, 1'b1, 2 * BIT);
        send(0, 8'h12, 0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_acc - a0 !== 2) begin errors++; $display("FAIL break_after_count: got %0d want 2", n_acc - a0); end
        checks++; if (acc_data !== 8'h12 || acc_fe !== 1'b0) begin errors++; $display("FAIL break_after_frame: got data=%h fe=%b want 12 0", acc_data, acc_fe); end
    endtask

    task automatic test_glitch;
        int a0 = n_acc;
        drive(0, 1'b0, 30);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 200);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        checks++; if (n_acc - a0 !== 0) begin errors++; $display("FAIL glitch_count: got %0d want 0", n_acc - a0); end
    endtask

    task automatic test_back_to_back;
        int a0 = n_acc, o0 = n_ovr;
        m_ready = 1'b0;
        send(0, 8'h11, 0, 1'b0, 1'b1);
        send(0, 8'h22, 0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("FAIL b2b_held: got valid=%b data=%h want 1 11", m_valid, m_data); end
        checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d want 1", n_ovr - o0); end
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", m_valid); end
        repeat (400) @(negedge clk);
        checks++; if (n_acc - a0 !== 1 || acc_data !== 8'h11) begin errors++; $display("FAIL b2b_delivered: got n=%0d data=%h want 1 11", n_acc - a0, acc_data); end
    endtask

    task automatic test_reset_mid;
        int a0;
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(0, 1'b0, BIT);
        drive(0, 1'b1, BIT / 2);
        #1 rst = 1'b1;
        #1;
        checks++; if (m_data !== 8'h00 || m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got data=%h valid=%b want 00 0", m_data, m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        a0 = n_acc;
        drive(0, 1'b1, 2 * BIT);
        send(0, 8'h0F, 0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", n_acc - a0); end
        checks++; if (acc_data !== 8'h0F || acc_fe !== 1'b0) begin errors++; $display("FAIL rstmid_data: got data=%h fe=%b want 0f 0", acc_data, acc_fe); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_break;
        test_glitch;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
